vid_framesync: RTL and testbench

Frame-alignment and checking stage for the HDMI video path. It accepts an AXI-style pixel stream, whose start point may be mid-frame, and discards pixels until a start of frame. It then forwards a frame-aligned stream with regenerated line and frame markers and flags any geometry violation against the programmed width and height. It sits between a pixel source (a frame reader, or a constant-pixel generator used as a fallback) and the HDMI encoder or video mux.

---
 rtl/vid_framesync.sv | 93 +++++++++
 tb/tb_vid_framesync.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vid_framesync.sv
// vid_framesync: aligns an AXI-style pixel stream to frame starts, regenerates
// line/frame markers from its own position counters and flags geometry violations.
module vid_framesync #(
   parameter int PW = 24,
   parameter int LGFRAME = 12,
   parameter bit OPT_TUSER_IS_SOF = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [LGFRAME-1:0] i_width,
   input  logic [LGFRAME-1:0] i_height,
   input  logic               S_VID_VALID,
   output logic               S_VID_READY,
   input  logic [PW-1:0]      S_VID_DATA,
   input  logic               S_VID_LAST,
   input  logic               S_VID_USER,
   output logic               M_VID_VALID,
   input  logic               M_VID_READY,
   output logic [PW-1:0]      M_VID_DATA,
   output logic               M_VID_LAST,
   output logic               M_VID_USER,
   output logic               o_locked,
   output logic               o_err
);
   typedef enum logic {SEARCH, LOCKED} state_t;
   state_t state_q, state_d;
   logic [LGFRAME-1:0] xpos_q, xpos_d, ypos_q, ypos_d, fx, fy, wm1, hm1;
   logic after_eof_q, acc, in_eol, in_eof, in_sof;
   logic exp_hlast, exp_vlast, exp_sof, mismatch, bad, fwd, f_hlast, f_vlast, f_sof;
   logic m_valid_q, m_last_q, m_user_q, err_q;
   logic [PW-1:0] m_data_q;

   assign S_VID_READY = !m_valid_q || M_VID_READY;
   assign acc = S_VID_VALID && S_VID_READY;

   always_comb begin
      wm1 = i_width - 1'b1;
      hm1 = i_height - 1'b1;
      in_eol = OPT_TUSER_IS_SOF ? S_VID_LAST : S_VID_USER;
      in_eof = S_VID_LAST && S_VID_USER;
      in_sof = OPT_TUSER_IS_SOF ? S_VID_USER : after_eof_q;
      exp_hlast = xpos_q == wm1;
      exp_vlast = ypos_q == hm1;
      exp_sof = xpos_q == '0 && ypos_q == '0;
      mismatch = (in_eol != exp_hlast) ||
                 (OPT_TUSER_IS_SOF ? (in_sof != exp_sof) : (in_eof != (exp_hlast && exp_vlast)));
      bad = acc && state_q == LOCKED && mismatch;
      fwd = acc && (state_q == SEARCH ? in_sof : (!mismatch || (OPT_TUSER_IS_SOF && in_sof)));
      // A beat that (re)starts a frame is always placed at pixel (0,0)
      fx = (state_q == SEARCH || mismatch) ? '0 : xpos_q;
      fy = (state_q == SEARCH || mismatch) ? '0 : ypos_q;
      f_hlast = fx == wm1;
      f_vlast = fy == hm1;
      f_sof = fx == '0 && fy == '0;
      xpos_d = fwd ? (f_hlast ? '0 : fx + 1'b1) : bad ? '0 : xpos_q;
      ypos_d = fwd ? (f_hlast ? (f_vlast ? '0 : fy + 1'b1) : fy) : bad ? '0 : ypos_q;
      state_d = fwd ? LOCKED : bad ? SEARCH : state_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= SEARCH;
         xpos_q <= '0;
         ypos_q <= '0;
         after_eof_q <= 1'b0;
         m_valid_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         xpos_q <= xpos_d;
         ypos_q <= ypos_d;
         if (acc) after_eof_q <= in_eof;
         err_q <= bad;
         if (fwd) m_valid_q <= 1'b1;
         else if (M_VID_READY) m_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (fwd) begin
         m_data_q <= S_VID_DATA;
         m_last_q <= OPT_TUSER_IS_SOF ? f_hlast : (f_hlast && f_vlast);
         m_user_q <= OPT_TUSER_IS_SOF ? f_sof : f_hlast;
      end
   end

   assign M_VID_VALID = m_valid_q;
   assign M_VID_DATA = m_data_q;
   assign M_VID_LAST = m_last_q;
   assign M_VID_USER = m_user_q;
   assign o_locked = state_q == LOCKED;
   assign o_err = err_q;
endmodule

// File: tb/tb_vid_framesync.sv
// tb_vid_framesync: directed and randomized-handshake checks of vid_framesync for
// both marker conventions, with a queue of expected output beats.
module tb_vid_framesync;
   localparam int PW = 24;
   localparam int LG = 12;
   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   logic [LG-1:0] i_width = LG'(4), i_height = LG'(3);
   logic S_VID_VALID = 1'b0, S_VID_LAST = 1'b0, S_VID_USER = 1'b0, M_VID_READY = 1'b1;
   logic [PW-1:0] S_VID_DATA = '0;
   logic sr1, v1, l1, u1, lk1, e1, sr0, v0, l0, u0, lk0, e0;
   logic [PW-1:0] d1, d0;
   logic s_ready, m_valid, m_last, m_user, m_locked, m_err;
   logic [PW-1:0] m_data;
   bit sel = 1'b1, rand_mode = 1'b0, hold_v = 1'b0;
   logic [31:0] hold_val;
   logic [25:0] q[$];
   int checks = 0, fails = 0, outs = 0, err_seen = 0, exp_errs = 0, dcnt = 1, w = 4, h = 3;

   always #5 i_clk = ~i_clk;

   vid_framesync #(.PW(PW), .LGFRAME(LG), .OPT_TUSER_IS_SOF(1'b1)) dut1 (
      .i_clk(i_clk), .i_reset(i_reset), .i_width(i_width), .i_height(i_height),
      .S_VID_VALID(S_VID_VALID), .S_VID_READY(sr1), .S_VID_DATA(S_VID_DATA),
      .S_VID_LAST(S_VID_LAST), .S_VID_USER(S_VID_USER),
      .M_VID_VALID(v1), .M_VID_READY(M_VID_READY), .M_VID_DATA(d1),
      .M_VID_LAST(l1), .M_VID_USER(u1), .o_locked(lk1), .o_err(e1));

   vid_framesync #(.PW(PW), .LGFRAME(LG), .OPT_TUSER_IS_SOF(1'b0)) dut0 (
      .i_clk(i_clk), .i_reset(i_reset), .i_width(i_width), .i_height(i_height),
      .S_VID_VALID(S_VID_VALID), .S_VID_READY(sr0), .S_VID_DATA(S_VID_DATA),
      .S_VID_LAST(S_VID_LAST), .S_VID_USER(S_VID_USER),
      .M_VID_VALID(v0), .M_VID_READY(M_VID_READY), .M_VID_DATA(d0),
      .M_VID_LAST(l0), .M_VID_USER(u0), .o_locked(lk0), .o_err(e0));

   assign s_ready = sel ? sr1 : sr0;
   assign m_valid = sel ? v1 : v0;
   assign m_data = sel ? d1 : d0;
   assign m_last = sel ? l1 : l0;
   assign m_user = sel ? u1 : u0;
   assign m_locked = sel ? lk1 : lk0;
   assign m_err = sel ? e1 : e0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: observe the output port at the falling edge, then step past the rising edge
   task automatic tick(output bit rdy);
      logic [25:0] e;
      @(negedge i_clk);
      rdy = s_ready;
      if (!i_reset && m_valid === 1'b1 && M_VID_READY) begin
         if (q.size() == 0) chk("unexpected_out", 32'(m_valid), 32'd0);
         else begin
            e = q.pop_front();
            chk("out_beat", 32'({m_data, m_last, m_user}), 32'(e));
            outs++;
         end
      end
      if (hold_v) chk("hold_stable", 32'({m_valid, m_data, m_last, m_user}), hold_val);
      hold_v = !i_reset && m_valid === 1'b1 && M_VID_READY === 1'b0;
      hold_val = 32'({1'b1, m_data, m_last, m_user});
      if (!i_reset && m_err === 1'b1) err_seen++;
      @(posedge i_clk);
      #1;
      if (rand_mode) M_VID_READY = 1'($urandom_range(0, 1));
   endtask

   // fwd: 0 dropped, 1 forwarded and scored, 2 forwarded but lost to reset
   task automatic send(input int d, input bit l, input bit u, input int fwd);
      bit r = 1'b0;
      int n = 0;
      if (rand_mode) repeat ($urandom_range(0, 2)) tick(r);
      S_VID_VALID = 1'b1;
      S_VID_DATA = PW'(d);
      S_VID_LAST = l;
      S_VID_USER = u;
      r = 1'b0;
      while (!r && n < 200) begin
         tick(r);
         n++;
      end
      S_VID_VALID = 1'b0;
      if (!r) chk("accept_timeout", 32'(n), 32'd0);
      if (fwd == 1) q.push_back({PW'(d), l, u});
      if (!rand_mode) chk("out_valid", 32'(m_valid), 32'(fwd != 0));
   endtask

   task automatic pix(input int x, input int y, input int fwd);
      bit l, u;
      if (sel) begin
         l = x == w - 1;
         u = x == 0 && y == 0;
      end else begin
         u = x == w - 1;
         l = x == w - 1 && y == h - 1;
      end
      send(dcnt, l, u, fwd);
      dcnt++;
   endtask

   task automatic frame_from(input int s);
      for (int i = s; i < w * h; i++) pix(i % w, i / w, 1);
   endtask

   task automatic drain();
      bit r;
      int n = 0;
      while ((q.size() != 0 || m_valid === 1'b1) && n < 1000) begin
         tick(r);
         n++;
      end
      tick(r);
      chk("drain_queue", 32'(q.size()), 32'd0);
   endtask

   task automatic rst();
      bit r;
      i_reset = 1'b1;
      tick(r);
      tick(r);
      i_reset = 1'b0;
   endtask

   initial begin
      bit r;
      rst();
      chk("reset_valid", 32'(m_valid), 32'd0);
      chk("reset_locked", 32'(m_locked), 32'd0);
      chk("reset_err", 32'(m_err), 32'd0);
      chk("reset_sready", 32'(s_ready), 32'd1);
      // Aligned 4x3 stream, three frames
      pix(0, 0, 1);
      chk("t1_lock_first", 32'(m_locked), 32'd1);
      frame_from(1);
      frame_from(0);
      frame_from(0);
      drain();
      chk("t1_outs", 32'(outs), 32'd36);
      chk("t1_no_err", 32'(err_seen), 32'd0);
      // Start at pixel (2,1): six beats dropped before lock
      rst();
      for (int i = 6; i < 12; i++) begin
         pix(i % 4, i / 4, 0);
         chk("t2_search", 32'(m_locked), 32'd0);
      end
      pix(0, 0, 1);
      chk("t2_lock", 32'(m_locked), 32'd1);
      chk("t2_user", 32'(m_user), 32'd1);
      frame_from(1);
      // Early LAST at (2,1)
      for (int i = 0; i < 6; i++) pix(i % 4, i / 4, 1);
      send(dcnt, 1'b1, 1'b0, 0);
      dcnt++;
      exp_errs++;
      chk("t3_err", 32'(m_err), 32'd1);
      chk("t3_unlock", 32'(m_locked), 32'd0);
      pix(3, 1, 0);
      chk("t3_err_pulse", 32'(m_err), 32'd0);
      for (int i = 8; i < 12; i++) pix(i % 4, i / 4, 0);
      pix(0, 0, 1);
      chk("t3_relock", 32'(m_locked), 32'd1);
      frame_from(1);
      // Premature sof at (1,2) relocks at once
      for (int i = 0; i < 9; i++) pix(i % 4, i / 4, 1);
      send(dcnt, 1'b0, 1'b1, 1);
      dcnt++;
      exp_errs++;
      chk("t4_err", 32'(m_err), 32'd1);
      chk("t4_locked", 32'(m_locked), 32'd1);
      frame_from(1);
      // Back-to-back premature sofs
      pix(0, 0, 1);
      repeat (2) begin
         send(dcnt, 1'b0, 1'b1, 1);
         dcnt++;
         exp_errs++;
         chk("bb_err", 32'(m_err), 32'd1);
         chk("bb_locked", 32'(m_locked), 32'd1);
      end
      frame_from(1);
      drain();
      chk("err_count_opt1", 32'(err_seen), 32'(exp_errs));
      // Random handshakes over ten frames
      rand_mode = 1'b1;
      repeat (10) frame_from(0);
      rand_mode = 1'b0;
      M_VID_READY = 1'b1;
      drain();
      chk("t5_locked", 32'(m_locked), 32'd1);
      chk("t5_err_count", 32'(err_seen), 32'(exp_errs));
      // LAST=end of frame convention, 3x3, starting mid-frame
      sel = 1'b0;
      w = 3;
      h = 3;
      i_width = LG'(3);
      i_height = LG'(3);
      rst();
      for (int i = 4; i < 9; i++) pix(i % 3, i / 3, 0);
      chk("t6_search", 32'(m_locked), 32'd0);
      pix(0, 0, 1);
      chk("t6_lock", 32'(m_locked), 32'd1);
      frame_from(1);
      pix(0, 0, 2);
      M_VID_READY = 1'b0;
      i_reset = 1'b1;
      tick(r);
      chk("t6_rst_valid", 32'(m_valid), 32'd0);
      chk("t6_rst_locked", 32'(m_locked), 32'd0);
      i_reset = 1'b0;
      M_VID_READY = 1'b1;
      for (int i = 1; i < 9; i++) pix(i % 3, i / 3, 0);
      chk("t6_research", 32'(m_locked), 32'd0);
      pix(0, 0, 1);
      chk("t6_relock", 32'(m_locked), 32'd1);
      frame_from(1);
      drain();
      chk("t6_err_count", 32'(err_seen), 32'(exp_errs));
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
